// File: rtl/servo_pkg.sv
// Shared constants and FSM encoding for the servo PWM generator/decoder pair.
package servo_pkg;

    localparam int unsigned US_PER_S   = 1_000_000;
    localparam int unsigned ANGLE_MAX  = 180;
    localparam int unsigned DEF_MIN_US = 1000;
    localparam int unsigned DEF_MAX_US = 2000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } servo_state_e;

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Control/result bundle of the servo PWM decoder; slave = decoder, master = consumer.
interface servo_pwm_decoder_if;

    logic        enable;
    logic        pwm_in;
    logic [15:0] pulse_us;
    logic [7:0]  angle;
    logic        valid;
    logic        range_err;
    logic        signal_lost;

    modport master (
        output enable, pwm_in,
        input  pulse_us, angle, valid, range_err, signal_lost
    );

    modport slave (
        input  enable, pwm_in,
        output pulse_us, angle, valid, range_err, signal_lost
    );

endinterface

// File: rtl/servo_pwm_sync.sv
// 2-FF synchronizer, optional glitch filter (SERVO_DEC_FILTER_EN) and edge strobes.
module servo_pwm_sync #(
    parameter int unsigned FILT_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

`ifdef SERVO_DEC_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    logic s1, s2, prev;

    // Flops reset high so a pulse already in progress at reset release is not measured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

    if (FILT_EN && FILT_CYC > 1) begin : g_filt
        localparam int FCW = $clog2(FILT_CYC);
        logic [FCW-1:0] fcnt;
        logic           flt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fcnt <= '0;
                flt  <= 1'b1;
            end else if (s2 == flt) begin
                fcnt <= '0;
            end else if (fcnt == FCW'(FILT_CYC - 1)) begin
                flt  <= s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FCW'(1);
            end
        end

        assign level = flt;
    end else begin : g_direct
        assign level = s2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= level;
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Hobby-servo PWM decoder: measures high time in us, maps it to 0..180 degrees.
// Optional input glitch filter enabled with `define SERVO_DEC_FILTER_EN.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned MIN_US     = DEF_MIN_US,
    parameter int unsigned MAX_US     = DEF_MAX_US,
    parameter int unsigned TIMEOUT_US = 25_000,
    parameter int unsigned FILT_CYC   = 4
) (
    input logic                clk,
    input logic                rst_n,
    servo_pwm_decoder_if.slave bus
);

    localparam int unsigned DIV    = CLK_HZ / US_PER_S;
    localparam int          PW     = $clog2(DIV);
    localparam int          DATA_W = 16;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v, input logic inc);
        if (inc && (v != '1)) return v + DATA_W'(1);
        return v;
    endfunction

    function automatic logic out_of_range(input logic [DATA_W-1:0] w);
        return (32'(w) < MIN_US) || (32'(w) > MAX_US);
    endfunction

    // Clamp to [MIN_US, MAX_US] then scale with truncation; 24-bit product cannot overflow.
    function automatic logic [7:0] angle_of(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0]   c;
        logic [DATA_W+7:0]   num;
        if (32'(w) < MIN_US)      c = DATA_W'(MIN_US);
        else if (32'(w) > MAX_US) c = DATA_W'(MAX_US);
        else                      c = w;
        num = (DATA_W+8)'(c - DATA_W'(MIN_US)) * (DATA_W+8)'(ANGLE_MAX);
        return 8'(num / (DATA_W+8)'(MAX_US - MIN_US));
    endfunction

    logic              rise, fall, level;
    servo_state_e      state, state_nxt;
    logic [PW-1:0]     presc;
    logic              us_tick;
    logic [DATA_W-1:0] width, per;
    logic              timeout, start, capture;

    logic [DATA_W-1:0] width_p0;
    logic              vld_p0;
    logic [7:0]        angle_p1;
    logic              range_err_p1, vld_p1, lost_p1;

    servo_pwm_sync #(.FILT_CYC(FILT_CYC)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (bus.pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign us_tick = (presc == PW'(DIV - 1));
    assign timeout = (state != IDLE) && (32'(per) > TIMEOUT_US);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!bus.enable || timeout) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nxt = HIGH;
                HIGH:    if (fall) state_nxt = LOW;
                LOW:     if (rise) state_nxt = HIGH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        start   = 1'b0;
        capture = 1'b0;
        if (bus.enable && !timeout) begin
            case (state)
                IDLE, LOW: start   = rise;
                HIGH:      capture = fall;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            width <= '0;
            per   <= '0;
        end else if (!bus.enable) begin
            presc <= '0;
            width <= '0;
            per   <= '0;
        end else begin
            presc <= (rise || us_tick) ? '0 : presc + PW'(1);
            if (start) begin
                width <= '0;
                per   <= '0;
            end else begin
                if (state == HIGH) width <= sat_inc(width, us_tick);
                if (state != IDLE) per   <= sat_inc(per, us_tick);
            end
        end
    end

    // Stage p0: capture width on the fall-detect cycle (includes a coincident tick).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_p0 <= '0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= capture;
            if (capture) width_p0 <= sat_inc(width, us_tick);
        end
    end

    // Stage p1: angle/range result and the one-cycle valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_p1     <= '0;
            range_err_p1 <= 1'b0;
            vld_p1       <= 1'b0;
            lost_p1      <= 1'b1;
        end else begin
            vld_p1 <= vld_p0 && bus.enable && !timeout;
            if (vld_p0 && bus.enable && !timeout) begin
                angle_p1     <= angle_of(width_p0);
                range_err_p1 <= out_of_range(width_p0);
            end
            if (!bus.enable || timeout) lost_p1 <= 1'b1;
            else if (vld_p0)            lost_p1 <= 1'b0;
        end
    end

    assign bus.pulse_us    = width_p0;
    assign bus.angle       = angle_p1;
    assign bus.valid       = vld_p1;
    assign bus.range_err   = range_err_p1;
    assign bus.signal_lost = lost_p1;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with a scaled clock (2 us-ticks per... 2 clocks per us) and short pulse range.
`timescale 1ns/1ps
module tb_servo_pwm_decoder;

    localparam int CLK_HZ     = 2_000_000;
    localparam int MIN_US     = 100;
    localparam int MAX_US     = 200;
    localparam int TIMEOUT_US = 500;
    localparam int FILT_CYC   = 4;
    localparam int DIV        = CLK_HZ / 1_000_000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    servo_pwm_decoder_if bus();

    servo_pwm_decoder #(
        .CLK_HZ     (CLK_HZ),
        .MIN_US     (MIN_US),
        .MAX_US     (MAX_US),
        .TIMEOUT_US (TIMEOUT_US),
        .FILT_CYC   (FILT_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        int p;
        int a;
        int e;
    } rec_t;

    rec_t seen[$];
    rec_t expq[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always @(negedge clk) begin
        if (bus.valid === 1'b1)
            seen.push_back('{int'(bus.pulse_us), int'(bus.angle), int'(bus.range_err)});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected result of one high pulse of hi_cyc clocks, straight from the decoding rules.
    function automatic rec_t model(input int hi_cyc);
        rec_t r;
        int   us, c;
        us = hi_cyc / DIV;
        if (us > 65535) us = 65535;
        c = (us < MIN_US) ? MIN_US : ((us > MAX_US) ? MAX_US : us);
        r.p = us;
        r.a = (c - MIN_US) * 180 / (MAX_US - MIN_US);
        r.e = (us < MIN_US || us > MAX_US) ? 1 : 0;
        return r;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int hi, input int lo);
        bus.pwm_in = 1'b1;
        cycles(hi);
        bus.pwm_in = 1'b0;
        cycles(lo);
        expq.push_back(model(hi));
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_count"}, seen.size(), expq.size());
        for (int i = 0; i < seen.size() && i < expq.size(); i++) begin
            chk($sformatf("%s_pulse%0d", tag, i), seen[i].p, expq[i].p);
            chk($sformatf("%s_angle%0d", tag, i), seen[i].a, expq[i].a);
            chk($sformatf("%s_err%0d", tag, i), seen[i].e, expq[i].e);
        end
        seen.delete();
        expq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pulse"}, bus.pulse_us, 0);
        chk({tag, "_angle"}, bus.angle, 0);
        chk({tag, "_valid"}, bus.valid, 0);
        chk({tag, "_err"},   bus.range_err, 0);
        chk({tag, "_lost"},  bus.signal_lost, 1);
    endtask

    initial begin
        int hi, lo;
        bus.enable = 1'b0;
        bus.pwm_in = 1'b0;

        // Reset state
        cycles(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        bus.enable = 1'b1;

        // Pin idle low longer than the timeout: still lost, no strobes
        cycles(1400);
        chk("idle_lost", bus.signal_lost, 1);
        check_frames("idle");

        // Nominal mid-position frames
        repeat (3) frame(300, 300);
        chk("nominal_lost", bus.signal_lost, 0);
        check_frames("nominal");

        // Range end points and out-of-range widths
        frame(200, 300);
        frame(400, 300);
        frame(500, 300);
        frame(198, 300);
        frame(402, 300);
        frame(100, 300);
        frame(301, 300);
        check_frames("range");

        // Randomized frames, period kept below the timeout
        for (int i = 0; i < 20; i++) begin
            hi = $urandom_range(600, 10);
            lo = $urandom_range(960 - hi, 20);
            frame(hi, lo);
        end
        check_frames("random");

        // Pin stuck high after a good frame
        frame(300, 300);
        bus.pwm_in = 1'b1;
        cycles(960);
        chk("stuck_before_lost", bus.signal_lost, 0);
        cycles(80);
        chk("stuck_after_lost", bus.signal_lost, 1);
        chk("stuck_pulse_kept", bus.pulse_us, 150);
        chk("stuck_angle_kept", bus.angle, 90);
        bus.pwm_in = 1'b0;
        cycles(50);
        check_frames("stuck");

        // Enable dropped and re-raised mid-pulse
        frame(300, 300);
        bus.pwm_in = 1'b1;
        cycles(40);
        bus.enable = 1'b0;
        cycles(2);
        chk("disable_lost", bus.signal_lost, 1);
        cycles(58);
        bus.enable = 1'b1;
        cycles(200);
        bus.pwm_in = 1'b0;
        cycles(300);
        chk("partial_lost", bus.signal_lost, 1);
        frame(240, 300);
        check_frames("enable");

        // Short glitch inside a pulse
        bus.pwm_in = 1'b1;
        cycles(10);
        bus.pwm_in = 1'b0;
        cycles(2);
        bus.pwm_in = 1'b1;
        cycles(288);
        bus.pwm_in = 1'b0;
        cycles(300);
`ifdef SERVO_DEC_FILTER_EN
        expq.push_back(model(300));
`else
        expq.push_back(model(10));
        expq.push_back(model(288));
`endif
        check_frames("glitch");

        // Async reset mid-pulse
        bus.pwm_in = 1'b1;
        cycles(100);
        rst_n = 1'b0;
        cycles(5);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        cycles(195);
        bus.pwm_in = 1'b0;
        cycles(300);
        chk("midreset_lost", bus.signal_lost, 1);
        frame(300, 300);
        chk("after_reset_lost", bus.signal_lost, 0);
        check_frames("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
